// File: rtl/adc_sequencer.sv
// adc_sequencer
//   Programs the preamp gains, then triggers the ADC at a run-time period and
//   box-car averages 2**AVG_LOG2 signed samples per channel. Re-programs the
//   amp when the requested gains differ from the latched ones, and raises
//   sticky flags for conversion timeouts and period overruns.
//
// Ports
//   CLK50MHZ     system clock
//   RST          synchronous reset, active high
//   en           run enable (sampled in IDLE / PERIOD_WAIT only)
//   period       cycles between adc_trig pulses (values below 2 act as 2)
//   gain_a/b     requested gain codes
//   err_clr      clears timeout_err / overrun_err
//   amp_trig     one-cycle request to the amp driver
//   amp_a/b      latched gain codes presented with amp_trig
//   amp_done     amp driver finished (pulse)
//   adc_trig     one-cycle conversion request
//   adc_done     conversion finished, adc_a/adc_b valid this cycle
//   adc_a/b      two's complement samples
//   avg_a/b      averaged results, held until the next avg_valid
//   avg_valid    one-cycle pulse with new averages
//   busy         controller is not idle
//   timeout_err  sticky: conversion did not finish within TIMEOUT cycles
//   overrun_err  sticky: period expired while a conversion was in flight
module adc_sequencer #(
  parameter int ADC_W    = 14,
  parameter int PERIOD_W = 32,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic                CLK50MHZ,
  input  logic                RST,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  input  logic [3:0]          gain_a,
  input  logic [3:0]          gain_b,
  input  logic                err_clr,
  output logic                amp_trig,
  output logic [3:0]          amp_a,
  output logic [3:0]          amp_b,
  input  logic                amp_done,
  output logic                adc_trig,
  input  logic                adc_done,
  input  logic [ADC_W-1:0]    adc_a,
  input  logic [ADC_W-1:0]    adc_b,
  output logic [ADC_W-1:0]    avg_a,
  output logic [ADC_W-1:0]    avg_b,
  output logic                avg_valid,
  output logic                busy,
  output logic                timeout_err,
  output logic                overrun_err
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AMP_SET,
    S_AMP_WAIT,
    S_PERIOD_WAIT,
    S_ADC_START,
    S_ADC_WAIT,
    S_ACCUM
  } state_t;

  state_t              r_state;
  logic [PERIOD_W-1:0] r_pcnt;
  logic [TO_W-1:0]     r_tcnt;
  logic [CNT_W-1:0]    r_count;
  logic                r_amp_trig;
  logic [3:0]          r_amp_a;
  logic [3:0]          r_amp_b;
  logic                r_adc_trig;
  logic                r_avg_valid;
  logic                r_busy;
  logic                r_timeout_err;
  logic                r_overrun_err;

  logic [PERIOD_W-1:0] w_period_m1;
  logic                w_expired;
  logic                w_gain_change;
  logic                w_capture;
  logic                w_accum;
  logic                w_block_end;
  logic                w_acc_clr;
  logic                w_pcnt_run;

  logic [1:0][ADC_W-1:0] w_adc_in;
  logic [1:0][ADC_W-1:0] w_avg;

  // Effective period minus one, with the period clamped to at least 2.
  assign w_period_m1   = (period < PERIOD_W'(2)) ? PERIOD_W'(1) : period - PERIOD_W'(1);
  assign w_expired     = (r_pcnt == '0);
  assign w_gain_change = ({gain_a, gain_b} != {r_amp_a, r_amp_b});
  assign w_capture     = (r_state == S_ADC_WAIT) && adc_done;
  assign w_accum       = (r_state == S_ACCUM);
  assign w_block_end   = w_accum && (r_count == LAST_CNT);
  assign w_acc_clr     = (r_state == S_PERIOD_WAIT) && (!en || (w_expired && w_gain_change));
  assign w_pcnt_run    = (r_state == S_PERIOD_WAIT) || (r_state == S_ADC_START) ||
                         (r_state == S_ADC_WAIT) || (r_state == S_ACCUM);

  assign w_adc_in = {adc_b, adc_a};

  // Per-channel sample capture, accumulation and averaging.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_ch
    logic signed [ADC_W-1:0] r_smp;
    logic signed [ACC_W-1:0] r_acc;
    logic [ADC_W-1:0]        r_avg;
    logic signed [ACC_W-1:0] w_acc_next;

    // The signed size cast sign-extends the sample into the wider accumulator.
    assign w_acc_next = r_acc + ACC_W'(r_smp);

    always_ff @(posedge CLK50MHZ) begin
      if (RST) begin
        r_smp <= '0;
        r_acc <= '0;
        r_avg <= '0;
      end else begin
        if (w_capture) begin
          r_smp <= w_adc_in[gi];
        end
        if (w_acc_clr || w_block_end) begin
          r_acc <= '0;
        end else if (w_accum) begin
          r_acc <= w_acc_next;
        end
        // Arithmetic shift gives the floor of the mean for negative sums.
        if (w_block_end) begin
          r_avg <= ADC_W'(w_acc_next >>> AVG_LOG2);
        end
      end
    end

    assign w_avg[gi] = r_avg;
  end

  // Control FSM. Pulse outputs are registered on the transition into the
  // state they belong to, so they are high exactly while that state is held.
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      r_state       <= S_IDLE;
      r_pcnt        <= '0;
      r_tcnt        <= '0;
      r_count       <= '0;
      r_amp_trig    <= 1'b0;
      r_amp_a       <= '0;
      r_amp_b       <= '0;
      r_adc_trig    <= 1'b0;
      r_avg_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_amp_trig  <= 1'b0;
      r_adc_trig  <= 1'b0;
      r_avg_valid <= 1'b0;

      if (err_clr) begin
        r_timeout_err <= 1'b0;
        r_overrun_err <= 1'b0;
      end

      // Saturating period counter; the reloads below take precedence.
      if (w_pcnt_run && (r_pcnt != '0)) begin
        r_pcnt <= r_pcnt - PERIOD_W'(1);
      end

      // Period ran out while a conversion is still in flight. Placed after
      // err_clr so a simultaneous set wins.
      if (((r_state == S_ADC_WAIT) || (r_state == S_ACCUM)) && (r_pcnt == '0)) begin
        r_overrun_err <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_state    <= S_AMP_SET;
            r_busy     <= 1'b1;
            r_amp_a    <= gain_a;
            r_amp_b    <= gain_b;
            r_amp_trig <= 1'b1;
          end
        end
        S_AMP_SET: begin
          r_state <= S_AMP_WAIT;
        end
        S_AMP_WAIT: begin
          if (amp_done) begin
            r_state <= S_PERIOD_WAIT;
            r_pcnt  <= w_period_m1;
          end
        end
        S_PERIOD_WAIT: begin
          if (!en) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_count <= '0;
          end else if (w_expired && w_gain_change) begin
            r_state    <= S_AMP_SET;
            r_amp_a    <= gain_a;
            r_amp_b    <= gain_b;
            r_amp_trig <= 1'b1;
            r_count    <= '0;
          end else if (w_expired) begin
            r_state    <= S_ADC_START;
            r_adc_trig <= 1'b1;
          end
        end
        S_ADC_START: begin
          r_state <= S_ADC_WAIT;
          r_tcnt  <= '0;
          // Reload folded together with this cycle's decrement, so the next
          // trigger lands exactly max(period,2) cycles after this one.
          r_pcnt  <= w_period_m1 - PERIOD_W'(1);
        end
        S_ADC_WAIT: begin
          if (adc_done) begin
            r_state <= S_ACCUM;
          end else if (r_tcnt == TO_LAST) begin
            r_state       <= S_PERIOD_WAIT;
            r_timeout_err <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + TO_W'(1);
          end
        end
        S_ACCUM: begin
          r_state <= S_PERIOD_WAIT;
          if (r_count == LAST_CNT) begin
            r_count     <= '0;
            r_avg_valid <= 1'b1;
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign amp_trig    = r_amp_trig;
  assign amp_a       = r_amp_a;
  assign amp_b       = r_amp_b;
  assign adc_trig    = r_adc_trig;
  assign avg_a       = w_avg[0];
  assign avg_b       = w_avg[1];
  assign avg_valid   = r_avg_valid;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
  assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_adc_sequencer.sv
// tb_adc_sequencer
//   Drives adc_sequencer with randomized samples and response delays and
//   compares it against a timing/averaging model expressed in whole cycles:
//   trigger spacing, overrun and timeout conditions, and floor-of-mean
//   block averages of the samples actually accepted.
module tb_adc_sequencer;

  localparam int ADC_W    = 14;
  localparam int PERIOD_W = 32;
  localparam int AVG_LOG2 = 2;
  localparam int TIMEOUT  = 64;
  localparam int NAVG     = 1 << AVG_LOG2;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic [PERIOD_W-1:0] period;
  logic [3:0]          gain_a;
  logic [3:0]          gain_b;
  logic                err_clr;
  logic                amp_trig;
  logic [3:0]          amp_a;
  logic [3:0]          amp_b;
  logic                amp_done;
  logic                adc_trig;
  logic                adc_done;
  logic [ADC_W-1:0]    adc_a;
  logic [ADC_W-1:0]    adc_b;
  logic [ADC_W-1:0]    avg_a;
  logic [ADC_W-1:0]    avg_b;
  logic                avg_valid;
  logic                busy;
  logic                timeout_err;
  logic                overrun_err;

  adc_sequencer #(
    .ADC_W(ADC_W), .PERIOD_W(PERIOD_W), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK50MHZ(clk), .RST(rst), .en(en), .period(period),
    .gain_a(gain_a), .gain_b(gain_b), .err_clr(err_clr),
    .amp_trig(amp_trig), .amp_a(amp_a), .amp_b(amp_b), .amp_done(amp_done),
    .adc_trig(adc_trig), .adc_done(adc_done), .adc_a(adc_a), .adc_b(adc_b),
    .avg_a(avg_a), .avg_b(avg_b), .avg_valid(avg_valid), .busy(busy),
    .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_valid = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (avg_valid === 1'b1) n_valid <= n_valid + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int m_sum_a, m_sum_b, m_n, m_valid;
  bit m_ovr, m_tmo;
  int exp_trig;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  function automatic int eff_period();
    return (period < 2) ? 2 : int'(period);
  endfunction

  function automatic int sx(input logic [ADC_W-1:0] v);
    return int'($signed(v));
  endfunction

  // Floor of sum / NAVG using plain integer arithmetic.
  function automatic int floor_mean(input int s);
    if (s >= 0) return s / NAVG;
    return -((-s + NAVG - 1) / NAVG);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_clear();
    m_sum_a = 0;
    m_sum_b = 0;
    m_n     = 0;
  endtask

  // Wait for an amp request, check it, then answer after a random delay.
  task automatic do_amp(input int exp_cyc);
    int lim;
    int a;
    lim = (exp_cyc >= 0) ? exp_cyc + 5 : cyc + 20;
    while (amp_trig !== 1'b1 && cyc < lim) step();
    if (exp_cyc >= 0) check_eq("amp_trig_cycle", 32'(cyc), 32'(exp_cyc));
    else              check_eq("amp_trig_seen", 32'(amp_trig), 32'd1);
    check_eq("amp_a", 32'(amp_a), 32'(gain_a));
    check_eq("amp_b", 32'(amp_b), 32'(gain_b));
    step();
    check_eq("amp_trig_pulse", 32'(amp_trig), 32'd0);
    steps(int'($urandom_range(0, 3)));
    amp_done = 1'b1;
    a = cyc;
    step();
    amp_done = 1'b0;
    exp_trig = a + eff_period() + 1;
    model_clear();
    $display("[TB] amp  gains a=%0d b=%0d done@%0d next trig@%0d", amp_a, amp_b, a, exp_trig);
  endtask

  // One conversion: wait for the trigger at the predicted cycle, then either
  // answer after 'delay' cycles or withhold the answer to force a timeout.
  task automatic do_conv(input int delay, input logic [ADC_W-1:0] va,
                         input logic [ADC_W-1:0] vb, input bit withhold);
    int t, d, p, ea, eb;
    bit fin;
    logic [ADC_W-1:0] xa, xb;
    while (adc_trig !== 1'b1 && cyc < exp_trig + 5) step();
    check_eq("adc_trig_cycle", 32'(cyc), 32'(exp_trig));
    t = cyc;
    p = eff_period();
    check_eq("busy_run", 32'(busy), 32'd1);
    step();
    check_eq("adc_trig_pulse", 32'(adc_trig), 32'd0);
    if (!withhold) begin
      steps(delay);
      d = cyc;
      adc_done = 1'b1;
      adc_a = va;
      adc_b = vb;
      step();
      adc_done = 1'b0;
      adc_a = ADC_W'($urandom);
      adc_b = ADC_W'($urandom);
      step();
      m_sum_a += sx(va);
      m_sum_b += sx(vb);
      m_n++;
      fin = (m_n == NAVG);
      check_eq("avg_valid", 32'(avg_valid), 32'(fin));
      if (fin) begin
        ea = floor_mean(m_sum_a);
        eb = floor_mean(m_sum_b);
        xa = ea[ADC_W-1:0];
        xb = eb[ADC_W-1:0];
        check_eq("avg_a", 32'(avg_a), 32'(xa));
        check_eq("avg_b", 32'(avg_b), 32'(xb));
        m_valid++;
        model_clear();
      end
      if (p <= delay + 3) m_ovr = 1'b1;
      check_eq("overrun_err", 32'(overrun_err), 32'(m_ovr));
      exp_trig = imax(t + p, d + 3);
      $display("[TB] conv trig@%0d done@%0d a=%0d b=%0d period=%0d avg=%0b next@%0d",
               t, d, sx(va), sx(vb), p, fin, exp_trig);
    end else begin
      steps(TIMEOUT - 1);
      check_eq("timeout_err_early", 32'(timeout_err), 32'(m_tmo));
      step();
      m_tmo = 1'b1;
      check_eq("timeout_err", 32'(timeout_err), 32'd1);
      check_eq("avg_valid_tmo", 32'(avg_valid), 32'd0);
      step();
      // Late answer after the abort must be ignored.
      adc_done = 1'b1;
      adc_a = 14'h0123;
      adc_b = 14'h0456;
      step();
      adc_done = 1'b0;
      if (p <= TIMEOUT + 1) m_ovr = 1'b1;
      check_eq("overrun_err_tmo", 32'(overrun_err), 32'(m_ovr));
      exp_trig = imax(t + p, t + TIMEOUT + 2);
      $display("[TB] conv trig@%0d timed out, late answer dropped, next@%0d", t, exp_trig);
    end
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    m_ovr = 1'b0;
    m_tmo = 1'b0;
    check_eq("err_clr_tmo", 32'(timeout_err), 32'd0);
    check_eq("err_clr_ovr", 32'(overrun_err), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_trigs"}, 32'({amp_trig, adc_trig, avg_valid}), 32'd0);
    check_eq({tag, "_amp"}, 32'({amp_a, amp_b}), 32'd0);
    check_eq({tag, "_avg"}, 32'({avg_a, avg_b}), 32'd0);
    check_eq({tag, "_errs"}, 32'({timeout_err, overrun_err}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lim, n_trig;
    rst = 1'b1; en = 1'b0; period = 100; gain_a = 4'd1; gain_b = 4'd2;
    err_clr = 1'b0; amp_done = 1'b0; adc_done = 1'b0; adc_a = '0; adc_b = '0;
    m_valid = 0; m_ovr = 1'b0; m_tmo = 1'b0; exp_trig = 0;
    model_clear();
    steps(3);
    check_idle_outputs("reset");
    rst = 1'b0;
    step();
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Bring-up and a plain ramp: mean of 4,8,12,16 is 10.
    en = 1'b1;
    do_amp(-1);
    do_conv(int'($urandom_range(0, 10)), 14'd4,  14'd1, 1'b0);
    do_conv(int'($urandom_range(0, 10)), 14'd8,  14'd2, 1'b0);
    do_conv(int'($urandom_range(0, 10)), 14'd12, 14'd3, 1'b0);
    do_conv(int'($urandom_range(0, 10)), 14'd16, 14'd4, 1'b0);

    // Negative samples floor toward minus infinity; full-scale positive holds.
    do_conv(int'($urandom_range(0, 10)), 14'h3FFD, 14'h1FFF, 1'b0);
    do_conv(int'($urandom_range(0, 10)), 14'h3FFD, 14'h1FFF, 1'b0);
    do_conv(int'($urandom_range(0, 10)), 14'h3FFE, 14'h1FFF, 1'b0);
    do_conv(int'($urandom_range(0, 10)), 14'h3FFE, 14'h1FFF, 1'b0);

    // Random samples and response delays.
    for (int i = 0; i < 10; i++)
      do_conv(int'($urandom_range(0, 20)), ADC_W'($urandom), ADC_W'($urandom), 1'b0);

    // Gain change mid-block: partial sums are discarded.
    for (int i = 0; i < NAVG && m_n != 2; i++)
      do_conv(int'($urandom_range(0, 10)), ADC_W'($urandom), ADC_W'($urandom), 1'b0);
    gain_a = 4'd3;
    do_amp(exp_trig);
    for (int i = 0; i < NAVG; i++)
      do_conv(int'($urandom_range(0, 10)), ADC_W'($urandom), ADC_W'($urandom), 1'b0);

    // Timeout, ignored late answer, then clear.
    do_conv(0, '0, '0, 1'b1);
    clear_errs();
    do_conv(int'($urandom_range(0, 10)), ADC_W'($urandom), ADC_W'($urandom), 1'b0);

    // Overrun with a short period and a slow conversion.
    period = 10;
    do_conv(int'($urandom_range(0, 5)), ADC_W'($urandom), ADC_W'($urandom), 1'b0);
    do_conv(14, ADC_W'($urandom), ADC_W'($urandom), 1'b0);
    clear_errs();
    // Periods below 2 behave as 2.
    period = 0;
    do_conv(0, ADC_W'($urandom), ADC_W'($urandom), 1'b0);
    do_conv(0, ADC_W'($urandom), ADC_W'($urandom), 1'b0);
    period = 1;
    do_conv(0, ADC_W'($urandom), ADC_W'($urandom), 1'b0);
    clear_errs();
    period = 4;
    do_conv(0, ADC_W'($urandom), ADC_W'($urandom), 1'b0);
    do_conv(0, ADC_W'($urandom), ADC_W'($urandom), 1'b0);
    do_conv(1, ADC_W'($urandom), ADC_W'($urandom), 1'b0);
    period = 60;
    do_conv(0, ADC_W'($urandom), ADC_W'($urandom), 1'b0);
    step();
    check_eq("avg_valid_count", 32'(n_valid), 32'(m_valid));

    // Reset while a conversion is pending.
    lim = cyc + 100;
    while (adc_trig !== 1'b1 && cyc < lim) step();
    check_eq("pre_rst_trig", 32'(adc_trig), 32'd1);
    steps(2);
    rst = 1'b1;
    step();
    check_idle_outputs("mid_rst");
    rst = 1'b0;
    m_ovr = 1'b0; m_tmo = 1'b0;
    model_clear();
    do_amp(-1);
    for (int i = 0; i < NAVG; i++)
      do_conv(int'($urandom_range(0, 10)), ADC_W'($urandom), ADC_W'($urandom), 1'b0);

    // Disable while waiting for the period: back to idle, no more triggers.
    en = 1'b0;
    step();
    check_eq("en_low_busy", 32'(busy), 32'd0);
    n_trig = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (adc_trig === 1'b1 || amp_trig === 1'b1) n_trig++;
    end
    check_eq("en_low_no_trig", 32'(n_trig), 32'd0);
    check_eq("avg_valid_total", 32'(n_valid), 32'(m_valid));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
